// File: rtl/comparator_serial_nbit_pkg.sv
// -----------------------------------------------------------------------------
// comparator_serial_nbit_pkg
//
// Shared definitions for the bit-serial magnitude comparator:
//   - state encoding of the control FSM
//   - packed result-flag record (GT/EQ/LT)
//   - default operand width and the bit-counter width helper
// -----------------------------------------------------------------------------
package comparator_serial_nbit_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  typedef struct packed {
    logic gt;
    logic eq;
    logic lt;
  } cmp_flags_t;

  // Bit counter must index WIDTH-1 down to 0; $clog2(1) is 0, so a
  // single-bit operand still gets a one-bit counter.
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage : comparator_serial_nbit_pkg

// File: rtl/comparator_1bit_data.sv
// -----------------------------------------------------------------------------
// comparator_1bit_data
//
// Combinational 1-bit magnitude compare cell. Exactly one output is high.
//
// Ports:
//   a   in  1  bit of operand A
//   b   in  1  bit of operand B
//   gt  out 1  a > b
//   eq  out 1  a == b
//   lt  out 1  a < b
// -----------------------------------------------------------------------------
module comparator_1bit_data (
  input  logic a,
  input  logic b,
  output logic gt,
  output logic eq,
  output logic lt
);

  assign gt = a & ~b;
  assign lt = ~a & b;
  assign eq = ~(a ^ b);

endmodule : comparator_1bit_data

// File: rtl/comparator_serial_nbit.sv
// -----------------------------------------------------------------------------
// comparator_serial_nbit
//
// Bit-serial WIDTH-bit unsigned magnitude comparator. On an accepted start
// the operands are captured into shift registers and walked MSB-first through
// a single 1-bit compare cell. The walk stops at the first differing bit (or
// after the LSB when the operands are equal); the result is latched into
// one-hot GT/EQ/LT flags and announced by a one-cycle done pulse.
//
// Ports:
//   clk    in  1      clock, rising edge
//   rst_n  in  1      asynchronous active-low reset
//   start  in  1      request strobe, only honoured in IDLE
//   A      in  WIDTH  operand A (unsigned), sampled on accepted start
//   B      in  WIDTH  operand B (unsigned), sampled on accepted start
//   busy   out 1      high while the operands are being walked
//   done   out 1      one-cycle pulse, flags valid from this cycle on
//   GT     out 1      A > B   (registered, holds until next result)
//   EQ     out 1      A == B  (registered, holds until next result)
//   LT     out 1      A < B   (registered, holds until next result)
// -----------------------------------------------------------------------------
module comparator_serial_nbit
  import comparator_serial_nbit_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             done,
  output logic             GT,
  output logic             EQ,
  output logic             LT
);

  localparam int CNT_W = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cmp_flags_t       flags_q, flags_d;

  logic cell_gt;
  logic cell_eq;
  logic cell_lt;

  comparator_1bit_data u_cell (
    .a  (sa_q[WIDTH-1]),
    .b  (sb_q[WIDTH-1]),
    .gt (cell_gt),
    .eq (cell_eq),
    .lt (cell_lt)
  );

  always_comb begin
    // NOTE: every signal gets its hold value first so no path through the
    // case statement leaves one unassigned, which would infer a latch.
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    cnt_d   = cnt_q;
    flags_d = flags_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          sa_d    = A;
          sb_d    = B;
          cnt_d   = CNT_W'(WIDTH - 1);
          state_d = ST_SHIFT;
        end
      end

      ST_SHIFT: begin
        // A differing bit decides the result at once; equal bits only
        // decide it once the LSB has been examined.
        if (!cell_eq || (cnt_q == '0)) begin
          flags_d.gt = cell_gt;
          flags_d.eq = cell_eq;
          flags_d.lt = cell_lt;
          state_d    = ST_FINISH;
        end else begin
          sa_d  = sa_q << 1;
          sb_d  = sb_q << 1;
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_FINISH: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      flags_q <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      flags_q <= flags_d;
    end
  end

  assign busy = (state_q == ST_SHIFT);
  assign done = (state_q == ST_FINISH);
  assign GT   = flags_q.gt;
  assign EQ   = flags_q.eq;
  assign LT   = flags_q.lt;

endmodule : comparator_serial_nbit

// File: tb/tb_comparator_serial_nbit.sv
// -----------------------------------------------------------------------------
// tb_comparator_serial_nbit
//
// Self-checking bench for comparator_serial_nbit at WIDTH = 8. A table of
// operand pairs with hand-computed flags and latencies is applied back to
// back; hand-written sequences cover reset, start-while-busy and reset in
// the middle of a walk. Outputs are sampled on the falling clock edge; the
// value seen at falling edge n after the accepting rising edge t0 is the
// value presented to rising edge t0+n.
// -----------------------------------------------------------------------------
module tb_comparator_serial_nbit;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [2:0]   flags;  // {GT, EQ, LT}
    int           lat;    // edges from acceptance to done
  } vec_t;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] A;
  logic [W-1:0] B;
  logic         busy;
  logic         done;
  logic         GT;
  logic         EQ;
  logic         LT;

  int n_checks;
  int n_pass;

  logic [2:0] prev_flags;

  comparator_serial_nbit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .GT    (GT),
    .EQ    (EQ),
    .LT    (LT)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Issue one request and follow it to completion. Called on a falling edge;
  // returns on the falling edge after done, so the next call is accepted in
  // the IDLE cycle right after FINISH. A non-zero inj pulses a competing
  // start (FF vs 00) at that falling-edge index while the walk is in flight.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [2:0] exp_flags, input int lat,
                        input int inj, input string tag);
    int   done_n;
    int   busy_cnt;
    int   extra_done;
    logic hold_ok;
    logic [2:0] got;
    A     = a;
    B     = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    done_n     = -1;
    busy_cnt   = 0;
    extra_done = 0;
    hold_ok    = 1'b1;
    got        = 3'b000;
    for (int n = 1; n <= W + 6; n++) begin
      @(negedge clk);
      if (n == inj) begin
        A     = 8'hFF;
        B     = 8'h00;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (done) begin
        if (done_n < 0) begin
          done_n = n;
          got    = {GT, EQ, LT};
        end else begin
          extra_done++;
        end
      end else if (done_n < 0 && {GT, EQ, LT} !== prev_flags) begin
        hold_ok = 1'b0;
      end
      if (done_n > 0 && n == done_n + 1) break;
    end
    start = 1'b0;
    check({tag, " done_latency"}, done_n, lat);
    check({tag, " busy_cycles"}, busy_cnt, lat - 1);
    check({tag, " single_done"}, extra_done, 0);
    check({tag, " flags"}, got, exp_flags);
    check({tag, " flags_held_before_done"}, hold_ok, 1'b1);
    prev_flags = exp_flags;
  endtask

  vec_t vecs[$];

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    prev_flags = 3'b000;

    // Flags are {GT, EQ, LT}; latency = W - k + 1 for first difference at k,
    // W + 1 for equal operands.
    vecs.push_back('{8'hA5, 8'h25, 3'b100, 2});
    vecs.push_back('{8'h3C, 8'h3C, 3'b010, 9});
    vecs.push_back('{8'h10, 8'h11, 3'b001, 9});
    vecs.push_back('{8'hFF, 8'h00, 3'b100, 2});  // back-to-back, LT drops
    vecs.push_back('{8'h00, 8'hFF, 3'b001, 2});
    vecs.push_back('{8'h12, 8'h34, 3'b001, 4});  // differ at bit 5
    vecs.push_back('{8'h55, 8'h54, 3'b100, 9});
    vecs.push_back('{8'h00, 8'h00, 3'b010, 9});
    vecs.push_back('{8'h0F, 8'h0E, 3'b100, 9});
    vecs.push_back('{8'h7F, 8'h80, 3'b001, 2});

    // Reset: start held high while in reset must be ignored.
    rst_n = 1'b0;
    start = 1'b1;
    A     = 8'hFF;
    B     = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 1'b0);
    check("reset_done", done, 1'b0);
    check("reset_flags", {GT, EQ, LT}, 3'b000);
    start = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_reset_busy", busy, 1'b0);
    check("post_reset_flags", {GT, EQ, LT}, 3'b000);

    // Table vectors, issued back to back.
    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].flags, vecs[i].lat, 0,
             $sformatf("vec%0d", i));
      if (i == 1) begin
        // Equal result must persist while idle.
        repeat (5) @(negedge clk);
        check("eq_hold_5_cycles", {GT, EQ, LT}, 3'b010);
      end
    end

    // Competing start during SHIFT is ignored.
    run_op(8'h01, 8'h02, 3'b001, 8, 3, "start_while_busy");

    // Reset in the middle of a walk.
    @(negedge clk);
    A     = 8'h00;
    B     = 8'h00;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("mid_shift_busy_before_reset", busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset_busy", busy, 1'b0);
    check("async_reset_done", done, 1'b0);
    check("async_reset_flags", {GT, EQ, LT}, 3'b000);
    begin
      int seen_done;
      seen_done = 0;
      repeat (3) begin
        @(negedge clk);
        if (done) seen_done++;
      end
      rst_n = 1'b1;
      repeat (W + 2) begin
        @(negedge clk);
        if (done || busy) seen_done++;
      end
      check("no_done_after_reset", seen_done, 0);
    end
    prev_flags = 3'b000;
    run_op(8'h80, 8'h7F, 3'b100, 2, 0, "after_reset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule : tb_comparator_serial_nbit
